// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 receiver
//
// Contents:
//   ps2_state_t            frame decoder state (IDLE, DATA, PARITY, STOP)
//   START_BIT / STOP_BIT   line levels that open and close a frame
//   DATA_BITS              payload bits per frame, sent LSB first
//   DEFAULT_FILTER_LEN     default depth of the PS2_CLK glitch filter
//   DEFAULT_TIMEOUT_CYCLES default mid-frame idle limit (1 ms at 25 MHz)
//   TIMEOUT_CNT_W          width of the optional mid-frame timeout counter
//   odd_parity_ok()        true when data plus parity bit carry an odd number of ones

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 25000;
  localparam int TIMEOUT_CNT_W          = 15;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 pin synchronizer and clock glitch filter
//
// Ports:
//   clk        in   system clock; all logic runs on the rising edge
//   rst_n      in   asynchronous active-low reset
//   ps2_clk    in   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   raw PS/2 data pin (asynchronous)
//   data_sync  out  synchronized PS/2 data
//   strobe     out  one-cycle pulse on each filtered PS/2 clock falling edge
//
// The filtered clock changes only after FILTER_LEN identical synchronized
// samples. Any shorter pulse is ignored. The filtered clock is registered, and
// strobe is registered in the same cycle as the filtered clock's 1->0 change.
// A clean pin fall therefore yields strobe 2 + FILTER_LEN + 1 cycles later.

module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic strobe
);

  logic [1:0]            clk_meta;
  logic [1:0]            data_meta;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  clk_filt;

  // Every register resets to 1, the PS/2 idle level, so that releasing
  // reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta  <= 2'b11;
      data_meta <= 2'b11;
      clk_hist  <= '1;
      clk_filt  <= 1'b1;
      strobe    <= 1'b0;
    end else begin
      clk_meta  <= {clk_meta[0], ps2_clk};
      data_meta <= {data_meta[0], ps2_data};
      clk_hist  <= {clk_hist[FILTER_LEN-2:0], clk_meta[1]};
      strobe    <= 1'b0;
      if (clk_hist == '0) begin
        clk_filt <= 1'b0;
        // Pulse only on the transition, not while the filtered clock stays low.
        strobe   <= clk_filt;
      end else if (&clk_hist) begin
        clk_filt <= 1'b1;
      end
    end
  end

  assign data_sync = data_meta[1];

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 keyboard receiver with valid/ready byte output
//
// Ports:
//   CLK_25MHZ   in   system clock
//   RESET_N     in   asynchronous active-low reset
//   PS2_CLK     in   raw PS/2 clock
//   PS2_DATA    in   raw PS/2 data
//   RX_DATA     out  received byte; valid while RX_VALID=1
//   RX_VALID    out  holding register full
//   RX_READY    in   consumer pops the byte when RX_VALID && RX_READY
//   ERR_PARITY  out  one-cycle pulse: odd parity violated
//   ERR_FRAME   out  one-cycle pulse: stop bit 0, or mid-frame timeout
//   OVERRUN     out  one-cycle pulse: good byte dropped because the holding register was full
//
// Build option PS2_RX_TIMEOUT_EN adds a mid-frame watchdog. The decoder then
// returns to IDLE with ERR_FRAME after TIMEOUT_CYCLES clocks without a strobe.
// Without this option, a stalled frame is cleared only by reset.

module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       ERR_PARITY,
  output logic       ERR_FRAME,
  output logic       OVERRUN
);

  logic       data_s;
  logic       strobe;
  ps2_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic       parity_q;
  logic       pop;
  logic       timeout;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk       (CLK_25MHZ),
    .rst_n     (RESET_N),
    .ps2_clk   (PS2_CLK),
    .ps2_data  (PS2_DATA),
    .data_sync (data_s),
    .strobe    (strobe)
  );

  assign pop = RX_VALID & RX_READY;

`ifdef PS2_RX_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_CNT_W-1:0] to_cnt;

  // A strobe in the same cycle means the line is still alive, so the strobe
  // wins and the timeout is suppressed.
  assign timeout = (state != IDLE) && !strobe && (to_cnt == TIMEOUT_LAST);

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      to_cnt <= '0;
    end else if (strobe || timeout || state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      RX_DATA    <= 8'h00;
      RX_VALID   <= 1'b0;
      ERR_PARITY <= 1'b0;
      ERR_FRAME  <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      ERR_PARITY <= 1'b0;
      ERR_FRAME  <= 1'b0;
      OVERRUN    <= 1'b0;

      // A load in the STOP branch below overrides this clear.
      if (pop) begin
        RX_VALID <= 1'b0;
      end

      if (timeout) begin
        state     <= IDLE;
        ERR_FRAME <= 1'b1;
      end else if (strobe) begin
        case (state)
          IDLE: begin
            // A high sample is a stray edge; stay idle without an error.
            if (data_s == START_BIT) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shift_q <= {data_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(DATA_BITS - 1)) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_q <= data_s;
            state    <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_s != STOP_BIT) begin
              ERR_FRAME <= 1'b1;
            end else if (!odd_parity_ok(shift_q, parity_q)) begin
              ERR_PARITY <= 1'b1;
            end else if (!RX_VALID || RX_READY) begin
              RX_DATA  <= shift_q;
              RX_VALID <= 1'b1;
            end else begin
              OVERRUN <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
